alu_serial: RTL and testbench

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_serial.sv | 138 +++++++++++++
 tb/tb_alu_serial.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Bit-serial ALU: add/sub/and/or on WIDTH-bit operands, one result bit per clock,
// LSB first, with a valid/ready handshake on both the operand and result sides.
module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;

  logic [1:0]        slice;
  logic [WIDTH-1:0]  y_shift;

  // One-bit ALU slice: returns {carry_out, result_bit}. Subtraction adds ~b with
  // the carry preloaded to 1, so the final carry is the "no borrow" flag.
  function automatic logic [1:0] bit_slice(input logic ai, input logic bi,
                                           input logic ci, input logic [1:0] opi);
    logic bb;
    logic s;
    logic co;
    bb = opi[0] ? ~bi : bi;
    s  = ai ^ bb ^ ci;
    co = (ai & bb) | (ai & ci) | (bb & ci);
    case (opi)
      2'b10:   bit_slice = {1'b0, ai & bi};
      2'b11:   bit_slice = {1'b0, ai | bi};
      default: bit_slice = {co, s};
    endcase
  endfunction

  // Next-state and datapath: capture in IDLE, shift one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    slice   = bit_slice(a_q[0], b_q[0], carry_q, op_q);
    y_shift = {slice[0], y_q[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = (op == OP_SUB);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        y_d     = y_shift;
        carry_d = slice[1];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = (op_q == OP_ADD || op_q == OP_SUB) ? slice[1] : 1'b0;
          zero_d  = (y_shift == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset clears them so nothing stale is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  // Operand shift registers; their contents only matter after a capture.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  // Handshake and result outputs decoded straight from registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    y         = y_q;
    cout      = cout_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial (WIDTH=8): directed vectors, backpressure,
// mid-run input changes, reset abort, and a random back-to-back run with stalls.
module tb_alu_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       cout;
  logic       zero;

  int n_cmp  = 0;
  int n_fail = 0;
  int ready_mode = 0;  // 0: always ready, 1: random stalls, 2: held low
  logic [9:0] sb[$];   // {y, cout, zero}

  alu_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  // Downstream readiness, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compare each accepted result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got y=%02h cout=%0b zero=%0b with nothing expected",
                 y, cout, zero);
      end else if (out_ready) begin
        logic [9:0] e;
        e = sb.pop_front();
        n_cmp++;
        if ({y, cout, zero} !== e) begin
          n_fail++;
          $display("FAIL result: got y=%02h cout=%0b zero=%0b expected y=%02h cout=%0b zero=%0b",
                   y, cout, zero, e[9:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] golden(input logic [7:0] ga, input logic [7:0] gb,
                                        input logic [1:0] gop);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    case (gop)
      2'b00:   begin s = {1'b0, ga} + {1'b0, gb}; r = s[7:0]; c = s[8]; end
      2'b01:   begin r = ga - gb; c = (ga >= gb); end
      2'b10:   begin r = ga & gb; c = 1'b0; end
      default: begin r = ga | gb; c = 1'b0; end
    endcase
    golden = {r, c, (r == 8'h00)};
  endfunction

  // Offer one operation; optionally record its expected result. Returns just after
  // the accepting edge, with the inputs scrambled to prove they were captured.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top,
                       input logic [9:0] exp, input bit push);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end else begin
      a = ta; b = tb_; op = top; in_valid = 1'b1;
      if (push) sb.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 0);
    chk("reset_cout", cout, 0);
    chk("reset_zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: result must appear exactly 8 edges after acceptance.
    issue(8'hFF, 8'h01, 2'b00, {8'h00, 1'b1, 1'b1}, 1);
    wait_valid(n);
    chk("latency_edges", n, 8);
    drain();

    // Directed arithmetic and logic vectors.
    issue(8'h05, 8'h07, 2'b01, {8'hFE, 1'b0, 1'b0}, 1);
    issue(8'h07, 8'h05, 2'b01, {8'h02, 1'b1, 1'b0}, 1);
    issue(8'hF0, 8'h3C, 2'b10, {8'h30, 1'b0, 1'b0}, 1);
    issue(8'hF0, 8'h0C, 2'b11, {8'hFC, 1'b0, 1'b0}, 1);
    issue(8'h33, 8'h33, 2'b01, {8'h00, 1'b1, 1'b1}, 1);
    issue(8'h80, 8'h80, 2'b00, {8'h00, 1'b1, 1'b1}, 1);
    issue(8'h0F, 8'h01, 2'b00, {8'h10, 1'b0, 1'b0}, 1);
    issue(8'h00, 8'h01, 2'b01, {8'hFF, 1'b0, 1'b0}, 1);
    issue(8'hAA, 8'h55, 2'b10, {8'h00, 1'b0, 1'b1}, 1);
    drain();

    // Backpressure: result and flags held for 20 cycles with out_ready low.
    ready_mode = 2;
    @(posedge clk);
    #3;
    issue(8'h12, 8'h34, 2'b00, {8'h46, 1'b0, 1'b0}, 1);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_y", y, 8'h46);
      chk("bp_cout", cout, 0);
      chk("bp_zero", zero, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    ready_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_ready && n < 10);
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // Reset during RUN at bit 4: no result may ever appear.
    issue(8'h99, 8'h11, 2'b00, 10'h0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Random back-to-back operations with random downstream stalls.
    ready_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [1:0] ro;
      ra = 8'($urandom); rb = 8'($urandom); ro = 2'($urandom);
      issue(ra, rb, ro, golden(ra, rb, ro), 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
